matrix_dma_loader: RTL and testbench

MATRIX_DMA_LOADER -- requirements
Module: matrix_dma_loader

---
 rtl/matrix_dma_loader.sv | 244 ++++++++++++++++++++++++
 tb/tb_matrix_dma_loader.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_dma_loader.sv
// ---------------------------------------------------------------------------
// matrix_dma_loader
//
// Copies an N x N matrix (N <= MAX_DIM) from memory into a local RAM. The
// source is read over an Avalon-MM burst master and written into the RAM
// one word at a time. The RAM is addressed as row*MAX_DIM + col.
//
// Configuration macro:
//   MATRIX_DMA_STRIDE_EN  defined   -> programmable source row pitch (STRIDE)
//                         undefined -> source rows are contiguous (pitch = N),
//                                      STRIDE writes ignored, reads return 0
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address/read/burstcount/waitrequest/readdata/readdatavalid
//                         Avalon burst read master
//   slave_address/slave_write/slave_writedata/slave_read/slave_readdata/
//   slave_waitrequest     CSR slave, zero wait states
//                         0 PTR, 1 CMD (write) / STATUS (read),
//                         2 STRIDE, 3 received word count (read only)
//   irq                   level completion interrupt, cleared by STATUS read
//   ram_addr/ram_data/ram_we
//                         local RAM write port
// ---------------------------------------------------------------------------
module matrix_dma_loader #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 30,
    parameter int MAX_DIM = 32,
    parameter int BURST   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic [ADDR_W-1:0]             address,
    output logic                          read,
    output logic [3:0]                    burstcount,
    input  logic                          waitrequest,
    input  logic [DATA_W-1:0]             readdata,
    input  logic                          readdatavalid,
    input  logic [1:0]                    slave_address,
    input  logic                          slave_write,
    input  logic [DATA_W-1:0]             slave_writedata,
    input  logic                          slave_read,
    output logic [DATA_W-1:0]             slave_readdata,
    output logic                          slave_waitrequest,
    output logic                          irq,
    output logic [2*$clog2(MAX_DIM)-1:0]  ram_addr,
    output logic [DATA_W-1:0]             ram_data,
    output logic                          ram_we
);

    localparam int DIM_W = $clog2(MAX_DIM);
    localparam int CNT_W = $clog2(MAX_DIM * MAX_DIM + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state;
    logic [DATA_W-1:0]   ptr;
`ifdef MATRIX_DMA_STRIDE_EN
    logic [DATA_W-1:0]   stride;
`endif
    logic [6:0]          n_reg;
    logic [6:0]          issue_row;
    logic [6:0]          issue_col;
    logic [DIM_W-1:0]    recv_row;
    logic [DIM_W-1:0]    recv_col;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    issued;
    logic                error;
    logic                aborted;
    logic                busy;

    logic                wr_ptr, wr_cmd, abort_wr, start_wr, status_rd;
    logic                accept, rdv_ok, row_done, last_burst;
    logic [6:0]          cmd_n, col_adv, nxt_row, nxt_col;
    logic [CNT_W-1:0]    cnt_next;
    logic [ADDR_W-1:0]   stride_eff, word_off, nxt_addr;

    // Burst length for a burst starting at column col: never crosses the row end.
    function automatic logic [3:0] burst_len(input logic [6:0] n, input logic [6:0] col);
        logic [6:0] rem;
        rem = n - col;
        return (rem < 7'(BURST)) ? 4'(rem) : 4'(BURST);
    endfunction

    assign busy              = (state != IDLE);
    assign slave_waitrequest = 1'b0;

    assign wr_ptr    = slave_write && (slave_address == 2'd0);
    assign wr_cmd    = slave_write && (slave_address == 2'd1);
    assign abort_wr  = wr_cmd && slave_writedata[DATA_W-1];
    assign start_wr  = wr_cmd && !slave_writedata[DATA_W-1];
    assign cmd_n     = slave_writedata[6:0];
    assign status_rd = slave_read && (slave_address == 2'd1);
    assign accept    = read && !waitrequest;
    // Responses that arrive while idle (e.g. stale ones after a reset) are dropped.
    assign rdv_ok    = readdatavalid && (state != IDLE);
    assign cnt_next  = count + CNT_W'(rdv_ok);

    // Position and address of the burst following the one currently presented.
    always_comb begin
`ifdef MATRIX_DMA_STRIDE_EN
        stride_eff = ADDR_W'(stride);
`else
        stride_eff = ADDR_W'(n_reg);
`endif
        col_adv    = issue_col + 7'(burstcount);
        row_done   = (col_adv >= n_reg);
        nxt_col    = row_done ? 7'd0 : col_adv;
        nxt_row    = row_done ? issue_row + 7'd1 : issue_row;
        last_burst = row_done && (issue_row == n_reg - 7'd1);
        word_off   = ADDR_W'(nxt_row) * stride_eff + ADDR_W'(nxt_col);
        nxt_addr   = ADDR_W'(ptr) + (word_off << 2);
    end

    always_comb begin
        slave_readdata = '0;
        case (slave_address)
            2'd0: slave_readdata = ptr;
            2'd1: slave_readdata = DATA_W'({error, irq, busy});
`ifdef MATRIX_DMA_STRIDE_EN
            2'd2: slave_readdata = stride;
`endif
            2'd3: slave_readdata = DATA_W'(count);
            default: slave_readdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
`ifdef MATRIX_DMA_STRIDE_EN
            stride     <= '0;
`endif
            n_reg      <= '0;
            issue_row  <= '0;
            issue_col  <= '0;
            recv_row   <= '0;
            recv_col   <= '0;
            count      <= '0;
            issued     <= '0;
            error      <= 1'b0;
            aborted    <= 1'b0;
            irq        <= 1'b0;
            read       <= 1'b0;
            address    <= '0;
            burstcount <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
        end else begin
            ram_we <= 1'b0;

            // A completion set later in this block overrides this clear.
            if (status_rd)
                irq <= 1'b0;

            if (wr_ptr)
                ptr <= slave_writedata;
`ifdef MATRIX_DMA_STRIDE_EN
            if (slave_write && (slave_address == 2'd2))
                stride <= slave_writedata;
`endif

            // Receive side: store each returned word at the next (row, col).
            if (rdv_ok) begin
                ram_we   <= 1'b1;
                ram_data <= readdata;
                ram_addr <= {recv_row, recv_col};
                count    <= cnt_next;
                if (7'(recv_col) + 7'd1 == n_reg) begin
                    recv_col <= '0;
                    recv_row <= recv_row + 1'b1;
                end else begin
                    recv_col <= recv_col + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start_wr) begin
                        if (cmd_n == 7'd0) begin
                            irq   <= 1'b1;
                            error <= 1'b0;
                        end else if (cmd_n > 7'(MAX_DIM)) begin
                            irq   <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            n_reg      <= cmd_n;
                            error      <= 1'b0;
                            aborted    <= 1'b0;
                            count      <= '0;
                            issued     <= '0;
                            issue_row  <= '0;
                            issue_col  <= '0;
                            recv_row   <= '0;
                            recv_col   <= '0;
                            read       <= 1'b1;
                            address    <= ADDR_W'(ptr);
                            burstcount <= burst_len(cmd_n, 7'd0);
                        end
                    end
                end

                ISSUE: begin
                    // Abort keeps only bursts already accepted, including one
                    // accepted on this very edge; a stalled burst is withdrawn.
                    if (abort_wr) begin
                        aborted <= 1'b1;
                        read    <= 1'b0;
                        state   <= DRAIN;
                        if (accept)
                            issued <= issued + CNT_W'(burstcount);
                    end else if (accept) begin
                        issued <= issued + CNT_W'(burstcount);
                        if (last_burst) begin
                            read  <= 1'b0;
                            state <= DRAIN;
                        end else begin
                            issue_row  <= nxt_row;
                            issue_col  <= nxt_col;
                            address    <= nxt_addr;
                            burstcount <= burst_len(n_reg, nxt_col);
                        end
                    end
                end

                DRAIN: begin
                    if (abort_wr)
                        aborted <= 1'b1;
                    if (cnt_next == issued) begin
                        state <= IDLE;
                        if (!aborted && !abort_wr)
                            irq <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_dma_loader.sv
// ---------------------------------------------------------------------------
// tb_matrix_dma_loader
//
// Directed bench for matrix_dma_loader. A behavioural Avalon slave answers
// accepted bursts with data derived from the word address, optionally
// stalling each burst for 3 cycles and inserting random response gaps.
// Accepted bursts and RAM writes are logged and compared against values
// computed here from the job parameters.
// ---------------------------------------------------------------------------
module tb_matrix_dma_loader;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 30;
    localparam int MAX_DIM = 32;
    localparam int BURST   = 4;
    localparam int RAM_W   = 2 * $clog2(MAX_DIM);

    logic               clk = 1'b0;
    logic               reset_n;
    logic [ADDR_W-1:0]  address;
    logic               read;
    logic [3:0]         burstcount;
    logic               waitrequest;
    logic [DATA_W-1:0]  readdata;
    logic               readdatavalid;
    logic [1:0]         slave_address;
    logic               slave_write;
    logic [DATA_W-1:0]  slave_writedata;
    logic               slave_read;
    logic [DATA_W-1:0]  slave_readdata;
    logic               slave_waitrequest;
    logic               irq;
    logic [RAM_W-1:0]   ram_addr;
    logic [DATA_W-1:0]  ram_data;
    logic               ram_we;

    int totalChecks = 0;
    int badChecks   = 0;

    bit                 stallMode = 1'b0;
    bit                 gapMode   = 1'b0;
    int                 stallCnt  = 0;
    bit                 prevStalled = 1'b0;
    logic [ADDR_W-1:0]  prevAddr;
    logic [3:0]         prevBc;
    int                 stableViol = 0;
    int                 weCount = 0;

    logic [ADDR_W-1:0]  respQ[$];
    logic [ADDR_W-1:0]  burstAddrLog[$];
    int                 burstLenLog[$];
    logic [RAM_W-1:0]   weAddrLog[$];
    logic [DATA_W-1:0]  weDataLog[$];

    matrix_dma_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .MAX_DIM(MAX_DIM),
        .BURST  (BURST)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .address          (address),
        .read             (read),
        .burstcount       (burstcount),
        .waitrequest      (waitrequest),
        .readdata         (readdata),
        .readdatavalid    (readdatavalid),
        .slave_address    (slave_address),
        .slave_write      (slave_write),
        .slave_writedata  (slave_writedata),
        .slave_read       (slave_read),
        .slave_readdata   (slave_readdata),
        .slave_waitrequest(slave_waitrequest),
        .irq              (irq),
        .ram_addr         (ram_addr),
        .ram_data         (ram_data),
        .ram_we           (ram_we)
    );

    always #5 clk = ~clk;

    // Memory content: each word carries its own byte address plus a marker.
    function automatic logic [DATA_W-1:0] wordData(input logic [ADDR_W-1:0] a);
        return 32'hC000_0000 | DATA_W'(a);
    endfunction

    // Behavioural Avalon slave and monitors, evaluated on the falling edge so
    // the values seen here are what the DUT samples on the next rising edge.
    always @(negedge clk) begin
        if (prevStalled && (read !== 1'b1 || address !== prevAddr || burstcount !== prevBc))
            stableViol++;

        if (ram_we === 1'b1) begin
            weAddrLog.push_back(ram_addr);
            weDataLog.push_back(ram_data);
            weCount++;
        end

        if (respQ.size() > 0 && (!gapMode || $urandom_range(0, 2) != 0)) begin
            readdatavalid = 1'b1;
            readdata      = wordData(respQ.pop_front());
        end else begin
            readdatavalid = 1'b0;
        end

        if (read === 1'b1) begin
            if (stallMode && stallCnt < 3) begin
                waitrequest = 1'b1;
                stallCnt++;
            end else begin
                waitrequest = 1'b0;
                stallCnt    = 0;
                burstAddrLog.push_back(address);
                burstLenLog.push_back(int'(burstcount));
                for (int k = 0; k < int'(burstcount); k++)
                    respQ.push_back(address + ADDR_W'(4 * k));
            end
        end else begin
            waitrequest = 1'b0;
            stallCnt    = 0;
        end

        prevStalled = (read === 1'b1) && waitrequest;
        prevAddr    = address;
        prevBc      = burstcount;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic csrWrite(input logic [1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(negedge clk);
        slave_write     = 1'b0;
    endtask

    task automatic csrRead(input logic [1:0] a, output logic [DATA_W-1:0] d);
        @(negedge clk);
        slave_address = a;
        slave_read    = 1'b1;
        #1 d = slave_readdata;
        @(negedge clk);
        slave_read    = 1'b0;
    endtask

    // Programs PTR, STRIDE and CMD, then checks read one cycle after the CMD write.
    task automatic applyStimulus(input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] s,
                                 input int n, input bit expectRead);
        burstAddrLog.delete();
        burstLenLog.delete();
        weAddrLog.delete();
        weDataLog.delete();
        weCount = 0;
        csrWrite(2'd0, p);
        csrWrite(2'd2, s);
        csrWrite(2'd1, DATA_W'(n));
        #1 checkOutput($sformatf("read_after_start_n%0d", n), read, expectRead);
    endtask

    task automatic waitIrq(input int budget);
        int c;
        c = 0;
        while (irq !== 1'b1 && c < budget) begin
            @(negedge clk);
            #2;
            c++;
        end
        checkOutput("irq_done", irq, 1);
    endtask

    // Compares logged bursts and RAM writes with the expected job, then reads
    // back the word count and STATUS and checks irq is cleared by that read.
    task automatic checkJob(input logic [ADDR_W-1:0] p, input int s, input int n);
        logic [ADDR_W-1:0] expAddr[$];
        int                expLen[$];
        int                se, col, bc, r, c, m;
        logic [DATA_W-1:0] v;
`ifdef MATRIX_DMA_STRIDE_EN
        se = s;
`else
        se = n;
`endif
        for (int row = 0; row < n; row++) begin
            col = 0;
            while (col < n) begin
                bc = (n - col < BURST) ? n - col : BURST;
                expAddr.push_back(p + ADDR_W'(4 * (row * se + col)));
                expLen.push_back(bc);
                col += bc;
            end
        end
        checkOutput("burst_count", burstAddrLog.size(), expAddr.size());
        m = (burstAddrLog.size() < expAddr.size()) ? burstAddrLog.size() : expAddr.size();
        for (int i = 0; i < m; i++) begin
            checkOutput($sformatf("burst%0d_addr", i), burstAddrLog[i], expAddr[i]);
            checkOutput($sformatf("burst%0d_len", i), burstLenLog[i], expLen[i]);
        end
        checkOutput("we_count", weAddrLog.size(), n * n);
        m = (weAddrLog.size() < n * n) ? weAddrLog.size() : n * n;
        for (int i = 0; i < m; i++) begin
            r = i / n;
            c = i % n;
            checkOutput($sformatf("we%0d_addr", i), weAddrLog[i], r * MAX_DIM + c);
            checkOutput($sformatf("we%0d_data", i), weDataLog[i],
                        wordData(p + ADDR_W'(4 * (r * se + c))));
        end
        csrRead(2'd3, v);
        checkOutput("count_csr", v, n * n);
        csrRead(2'd1, v);
        checkOutput("status_done", v, 32'h2);
        checkOutput("irq_cleared", irq, 0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] v;
        int c;

        reset_n         = 1'b0;
        slave_address   = 2'd1;
        slave_write     = 1'b0;
        slave_read      = 1'b0;
        slave_writedata = '0;
        waitrequest     = 1'b0;
        readdatavalid   = 1'b0;
        readdata        = '0;

        #3;
        $display("[TB] reset state");
        checkOutput("reset_read", read, 0);
        checkOutput("reset_irq", irq, 0);
        checkOutput("reset_ram_we", ram_we, 0);
        checkOutput("reset_address", address, 0);
        checkOutput("reset_burstcount", burstcount, 0);
        checkOutput("reset_status", slave_readdata, 0);
        checkOutput("slave_waitrequest", slave_waitrequest, 0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] N=4 PTR=0x1000 STRIDE=4");
        applyStimulus(32'h1000, 32'd4, 4, 1'b1);
        waitIrq(500);
        checkJob(30'h1000, 4, 4);

        $display("[TB] N=5 split bursts");
        applyStimulus(32'h2000, 32'd5, 5, 1'b1);
        waitIrq(500);
        checkJob(30'h2000, 5, 5);
        checkOutput("last_ram_addr",
                    (weAddrLog.size() > 0) ? weAddrLog[weAddrLog.size() - 1] : {RAM_W{1'b1}},
                    4 * MAX_DIM + 4);

        $display("[TB] N=2 PTR=0 STRIDE=8");
        applyStimulus(32'h0, 32'd8, 2, 1'b1);
        waitIrq(500);
        checkJob(30'h0, 8, 2);
        csrRead(2'd2, v);
`ifdef MATRIX_DMA_STRIDE_EN
        checkOutput("row1_addr", (burstAddrLog.size() > 1) ? burstAddrLog[1] : '1, 30'h20);
        checkOutput("stride_csr", v, 32'd8);
`else
        checkOutput("row1_addr", (burstAddrLog.size() > 1) ? burstAddrLog[1] : '1, 30'h8);
        checkOutput("stride_csr", v, 32'd0);
`endif

        $display("[TB] stalls and response gaps");
        stallMode  = 1'b1;
        gapMode    = 1'b1;
        stableViol = 0;
        applyStimulus(32'h300, 32'd4, 4, 1'b1);
        waitIrq(2000);
        checkOutput("stall_stable", stableViol, 0);
        checkJob(30'h300, 4, 4);
        stallMode = 1'b0;
        gapMode   = 1'b0;

        $display("[TB] N too large, then N=0");
        applyStimulus(32'h400, 32'd4, 40, 1'b0);
        checkOutput("irq_err_next", irq, 1);
        repeat (5) @(negedge clk);
        checkOutput("err_no_burst", burstAddrLog.size(), 0);
        csrRead(2'd1, v);
        checkOutput("status_err", v, 32'h6);
        checkOutput("irq_clear_err", irq, 0);
        applyStimulus(32'h400, 32'd4, 0, 1'b0);
        checkOutput("irq_zero_next", irq, 1);
        csrRead(2'd1, v);
        checkOutput("status_zero", v, 32'h2);
        checkOutput("irq_clear_zero", irq, 0);
        csrRead(2'd1, v);
        checkOutput("status_quiet", v, 32'h0);
        checkOutput("zero_no_burst", burstAddrLog.size(), 0);

        $display("[TB] abort after second burst");
        stallMode = 1'b1;
        applyStimulus(32'h500, 32'd4, 4, 1'b1);
        c = 0;
        while (burstAddrLog.size() < 2 && c < 200) begin
            @(negedge clk);
            #2;
            c++;
        end
        checkOutput("abort_reach2", burstAddrLog.size(), 2);
        csrWrite(2'd1, 32'h8000_0000);
        c = 0;
        v = 32'h1;
        while (v[0] && c < 200) begin
            csrRead(2'd1, v);
            c++;
        end
        checkOutput("abort_idle", v, 32'h0);
        stallMode = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("abort_bursts", burstAddrLog.size(), 2);
        checkOutput("abort_we", weCount, 8);
        checkOutput("abort_irq", irq, 0);
        csrRead(2'd3, v);
        checkOutput("abort_count", v, 32'd8);

        $display("[TB] reset mid-job");
        stallMode = 1'b1;
        applyStimulus(32'h600, 32'd4, 4, 1'b1);
        c = 0;
        while (burstAddrLog.size() < 1 && c < 200) begin
            @(negedge clk);
            #2;
            c++;
        end
        @(negedge clk);
        #1 reset_n = 1'b0;
        weCount = 0;
        slave_address = 2'd1;
        #1;
        checkOutput("rst_read", read, 0);
        checkOutput("rst_ram_we", ram_we, 0);
        checkOutput("rst_irq", irq, 0);
        checkOutput("rst_address", address, 0);
        checkOutput("rst_burstcount", burstcount, 0);
        checkOutput("rst_ram_addr", ram_addr, 0);
        checkOutput("rst_ram_data", ram_data, 0);
        checkOutput("rst_status", slave_readdata, 0);
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        stallMode = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("post_reset_drop", weCount, 0);
        checkOutput("resp_drained", respQ.size(), 0);
        checkOutput("post_reset_read", read, 0);
        csrRead(2'd3, v);
        checkOutput("post_reset_count", v, 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
